// File: rtl/ysyx_220066_pkg.sv
// Shared encodings for the EX-stage ALU issue path: opcodes, aluctr fields
// and the beat carried from the decoder through the skid buffer.
package ysyx_220066_pkg;

    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP       = 7'h33;
    localparam logic [6:0] OP_IMM32 = 7'h1B;
    localparam logic [6:0] OP32     = 7'h3B;
    localparam logic [6:0] LUI      = 7'h37;
    localparam logic [6:0] AUIPC    = 7'h17;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SLL   = 3'd1;
    localparam logic [2:0] ALU_SLT   = 3'd2;
    localparam logic [2:0] ALU_PASSB = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SR    = 3'd5;
    localparam logic [2:0] ALU_OR    = 3'd6;
    localparam logic [2:0] ALU_AND   = 3'd7;

    localparam int ALUCTR_W   = 4;
    localparam int ALUCTR_SUB = 3;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [4:0]  aluctr;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } issue_beat_t;

    // funct3 maps straight onto the ALU op, except sltu which shares the slt op
    function automatic logic [2:0] f3_op(input logic [2:0] funct3);
        logic [2:0] op;
        case (funct3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLT;
            3'd4:    op = ALU_XOR;
            3'd5:    op = ALU_SR;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [4:0] alu_ctl(input logic w, input logic sub, input logic [2:0] op);
        logic [4:0] ctl;
        ctl             = {2'b00, op};
        ctl[ALUCTR_W]   = w;
        ctl[ALUCTR_SUB] = sub;
        return ctl;
    endfunction

endpackage

// File: rtl/ysyx_220066_alu_issue_dec.sv
// Combinational RV64I integer-ALU decoder: instruction + operands -> issue beat.
// Unrecognised encodings produce an all-zero beat flagged illegal, rd preserved.
module ysyx_220066_alu_issue_dec
    import ysyx_220066_pkg::*;
(
    input  logic [31:0]  inst_i,
    input  logic [63:0]  pc_i,
    input  logic [63:0]  rs1_i,
    input  logic [63:0]  rs2_i,
    output issue_beat_t  beat_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [5:0]  funct6;
    logic [4:0]  rd;
    logic [63:0] imm_i;
    logic [63:0] imm_u;
    logic [63:0] shamt6;
    logic [63:0] shamt5;
    logic        legal;
    logic [4:0]  ctl;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        unused_rs1_idx;

    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign funct6 = inst_i[31:26];
    assign imm_i  = {{52{inst_i[31]}}, inst_i[31:20]};
    assign imm_u  = {{32{inst_i[31]}}, inst_i[31:12], 12'b0};
    assign shamt6 = {58'b0, inst_i[25:20]};
    assign shamt5 = {59'b0, inst_i[24:20]};

    // Register indices are resolved upstream; only the values arrive here.
    assign unused_rs1_idx = ^inst_i[19:15];

    always_comb begin
        legal = 1'b0;
        ctl   = '0;
        opa   = '0;
        opb   = '0;
        case (opcode)
            OP_IMM: begin
                opa   = rs1_i;
                opb   = imm_i;
                legal = 1'b1;
                ctl   = alu_ctl(1'b0, funct3 == 3'b010, f3_op(funct3));
                if (funct3 == 3'b001) begin
                    opb   = shamt6;
                    legal = (funct6 == 6'b000000);
                end else if (funct3 == 3'b101) begin
                    opb   = shamt6;
                    legal = (funct6 == 6'b000000) || (funct6 == 6'b010000);
                    ctl   = alu_ctl(1'b0, funct6[4], ALU_SR);
                end
            end
            OP: begin
                opa = rs1_i;
                opb = rs2_i;
                if (funct7 == FUNCT7_BASE) begin
                    legal = 1'b1;
                    ctl   = alu_ctl(1'b0, funct3 == 3'b010, f3_op(funct3));
                end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    ctl   = alu_ctl(1'b0, 1'b1, f3_op(funct3));
                end
            end
            OP_IMM32: begin
                opa = rs1_i;
                case (funct3)
                    3'b000: begin
                        legal = 1'b1;
                        opb   = imm_i;
                        ctl   = alu_ctl(1'b1, 1'b0, ALU_ADD);
                    end
                    3'b001: begin
                        legal = (funct7 == FUNCT7_BASE);
                        opb   = shamt5;
                        ctl   = alu_ctl(1'b1, 1'b0, ALU_SLL);
                    end
                    3'b101: begin
                        legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
                        opb   = shamt5;
                        ctl   = alu_ctl(1'b1, funct7[5], ALU_SR);
                    end
                    default: ;
                endcase
            end
            OP32: begin
                opa = rs1_i;
                opb = rs2_i;
                if (funct7 == FUNCT7_BASE &&
                    (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    ctl   = alu_ctl(1'b1, 1'b0, f3_op(funct3));
                end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    ctl   = alu_ctl(1'b1, 1'b1, f3_op(funct3));
                end
            end
            LUI: begin
                legal = 1'b1;
                ctl   = alu_ctl(1'b0, 1'b0, ALU_PASSB);
                opb   = imm_u;
            end
            AUIPC: begin
                legal = 1'b1;
                ctl   = alu_ctl(1'b0, 1'b0, ALU_ADD);
                opa   = pc_i;
                opb   = imm_u;
            end
            default: ;
        endcase
    end

    // Illegal beats carry no operands so the ALU sees a harmless add of zeros.
    always_comb begin
        beat_o.aluctr  = legal ? ctl : 5'b0;
        beat_o.a       = legal ? opa : 64'b0;
        beat_o.b       = legal ? opb : 64'b0;
        beat_o.rd      = rd;
        beat_o.wen     = legal && (rd != 5'd0);
        beat_o.illegal = !legal;
    end

endmodule

// File: rtl/ysyx_220066_alu_issue.sv
// ALU issue stage: decode then 2-entry skid buffer; 1-cycle latency, full throughput.
// in_ready is !skid_valid (registered only); flush clears both entries next edge.
module ysyx_220066_alu_issue
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_aluctr,
    output logic [XLEN-1:0] out_data_a,
    output logic [XLEN-1:0] out_data_b,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);

    issue_beat_t dec_beat;
    issue_beat_t out_q;
    issue_beat_t out_d;
    issue_beat_t skid_q;
    issue_beat_t skid_d;
    logic        out_vld_q;
    logic        out_vld_d;
    logic        skid_vld_q;
    logic        skid_vld_d;
    logic        accept;
    logic        out_free;

    ysyx_220066_alu_issue_dec u_dec (
        .inst_i (in_inst),
        .pc_i   (in_pc),
        .rs1_i  (in_rs1),
        .rs2_i  (in_rs2),
        .beat_o (dec_beat)
    );

    assign in_ready = !skid_vld_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_vld_q || out_ready;

    // The skid entry, when present, is always older than anything arriving now.
    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_free) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = dec_beat;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = dec_beat;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign out_valid   = out_vld_q;
    assign out_aluctr  = out_q.aluctr;
    assign out_data_a  = out_q.a;
    assign out_data_b  = out_q.b;
    assign out_rd      = out_q.rd;
    assign out_wen     = out_q.wen;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_ysyx_220066_alu_issue.sv
// Bench for the ALU issue stage: directed vector table, backpressure/flush/reset
// sequences, and random traffic checked against a mask/match decode + queue model.
module tb_ysyx_220066_alu_issue;

    typedef struct packed {
        logic [4:0]  aluctr;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        exp_t        exp;
    } vec_t;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        logic [4:0]  ctl;
        int          asel;
        int          bsel;
    } pat_t;

    localparam int A_RS1 = 0, A_ZERO = 1, A_PC = 2;
    localparam int B_RS2 = 0, B_IMMI = 1, B_SH6 = 2, B_SH5 = 3, B_IMMU = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [63:0] in_rs1;
    logic [63:0] in_rs2;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_aluctr;
    logic [63:0] out_data_a;
    logic [63:0] out_data_b;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_illegal;

    int   n_cmp  = 0;
    int   n_fail = 0;
    pat_t pats[$];
    exp_t q[$];
    vec_t vecs[13];
    logic [6:0] alu_opcodes[6] = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h17};

    ysyx_220066_alu_issue #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_aluctr  (out_aluctr),
        .out_data_a  (out_data_a),
        .out_data_b  (out_data_b),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic add_pat(input logic [31:0] mask, input logic [31:0] match,
                           input logic [4:0] ctl, input int asel, input int bsel);
        pat_t p;
        p.mask = mask; p.match = match; p.ctl = ctl; p.asel = asel; p.bsel = bsel;
        pats.push_back(p);
    endtask

    task automatic init_pats();
        add_pat(32'h0000707F, 32'h00000013, 5'b00000, A_RS1, B_IMMI); // addi
        add_pat(32'h0000707F, 32'h00002013, 5'b01010, A_RS1, B_IMMI); // slti
        add_pat(32'h0000707F, 32'h00003013, 5'b00010, A_RS1, B_IMMI); // sltiu
        add_pat(32'h0000707F, 32'h00004013, 5'b00100, A_RS1, B_IMMI); // xori
        add_pat(32'h0000707F, 32'h00006013, 5'b00110, A_RS1, B_IMMI); // ori
        add_pat(32'h0000707F, 32'h00007013, 5'b00111, A_RS1, B_IMMI); // andi
        add_pat(32'hFC00707F, 32'h00001013, 5'b00001, A_RS1, B_SH6);  // slli
        add_pat(32'hFC00707F, 32'h00005013, 5'b00101, A_RS1, B_SH6);  // srli
        add_pat(32'hFC00707F, 32'h40005013, 5'b01101, A_RS1, B_SH6);  // srai
        add_pat(32'hFE00707F, 32'h00000033, 5'b00000, A_RS1, B_RS2);  // add
        add_pat(32'hFE00707F, 32'h40000033, 5'b01000, A_RS1, B_RS2);  // sub
        add_pat(32'hFE00707F, 32'h00001033, 5'b00001, A_RS1, B_RS2);  // sll
        add_pat(32'hFE00707F, 32'h00002033, 5'b01010, A_RS1, B_RS2);  // slt
        add_pat(32'hFE00707F, 32'h00003033, 5'b00010, A_RS1, B_RS2);  // sltu
        add_pat(32'hFE00707F, 32'h00004033, 5'b00100, A_RS1, B_RS2);  // xor
        add_pat(32'hFE00707F, 32'h00005033, 5'b00101, A_RS1, B_RS2);  // srl
        add_pat(32'hFE00707F, 32'h40005033, 5'b01101, A_RS1, B_RS2);  // sra
        add_pat(32'hFE00707F, 32'h00006033, 5'b00110, A_RS1, B_RS2);  // or
        add_pat(32'hFE00707F, 32'h00007033, 5'b00111, A_RS1, B_RS2);  // and
        add_pat(32'h0000707F, 32'h0000001B, 5'b10000, A_RS1, B_IMMI); // addiw
        add_pat(32'hFE00707F, 32'h0000101B, 5'b10001, A_RS1, B_SH5);  // slliw
        add_pat(32'hFE00707F, 32'h0000501B, 5'b10101, A_RS1, B_SH5);  // srliw
        add_pat(32'hFE00707F, 32'h4000501B, 5'b11101, A_RS1, B_SH5);  // sraiw
        add_pat(32'hFE00707F, 32'h0000003B, 5'b10000, A_RS1, B_RS2);  // addw
        add_pat(32'hFE00707F, 32'h4000003B, 5'b11000, A_RS1, B_RS2);  // subw
        add_pat(32'hFE00707F, 32'h0000103B, 5'b10001, A_RS1, B_RS2);  // sllw
        add_pat(32'hFE00707F, 32'h0000503B, 5'b10101, A_RS1, B_RS2);  // srlw
        add_pat(32'hFE00707F, 32'h4000503B, 5'b11101, A_RS1, B_RS2);  // sraw
        add_pat(32'h0000007F, 32'h00000037, 5'b00011, A_ZERO, B_IMMU); // lui
        add_pat(32'h0000007F, 32'h00000017, 5'b00000, A_PC, B_IMMU);   // auipc
    endtask

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc,
                                        input logic [63:0] rs1, input logic [63:0] rs2);
        exp_t r;
        bit   found = 0;
        longint imm;
        r = '0;
        r.rd = inst[11:7];
        foreach (pats[i]) begin
            if (!found && ((inst & pats[i].mask) == pats[i].match)) begin
                found = 1;
                r.aluctr = pats[i].ctl;
                case (pats[i].asel)
                    A_RS1:   r.a = rs1;
                    A_PC:    r.a = pc;
                    default: r.a = 64'd0;
                endcase
                case (pats[i].bsel)
                    B_RS2:  r.b = rs2;
                    B_IMMI: begin imm = longint'(signed'(inst[31:20])); r.b = imm; end
                    B_SH6:  r.b = 64'(inst[25:20]);
                    B_SH5:  r.b = 64'(inst[24:20]);
                    default: begin imm = longint'(signed'({inst[31:12], 12'h000})); r.b = imm; end
                endcase
            end
        end
        r.illegal = !found;
        r.wen     = found && (r.rd != 5'd0);
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        int          k   = $urandom_range(0, 9);
        logic [31:0] w   = $urandom;
        int          idx;
        if (k < 6) begin
            idx = $urandom_range(0, pats.size() - 1);
            w   = (w & ~pats[idx].mask) | pats[idx].match;
        end else if (k < 9) begin
            w[6:0] = alu_opcodes[$urandom_range(0, 5)];
        end
        return w;
    endfunction

    function automatic exp_t dut_beat();
        return {out_aluctr, out_data_a, out_data_b, out_rd, out_wen, out_illegal};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_out_valid"}, out_valid, q.size() > 0);
        chk({tag, "_in_ready"}, in_ready, q.size() < 2);
        if (q.size() > 0) chk({tag, "_beat"}, dut_beat(), q[0]);
    endtask

    // One clock: model decides accept/pop from pre-edge state, DUT sampled 1ns after edge.
    task automatic tick(input string tag);
        bit   acc;
        bit   pop;
        exp_t nb;
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        nb  = ref_decode(in_inst, in_pc, in_rs1, in_rs2);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(nb);
        end
        check_model(tag);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] rs1, input logic [63:0] rs2);
        in_inst = inst; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    initial begin
        init_pats();
        vecs[0]  = '{32'hFFF00293, 64'h0, 64'h0, 64'h0,
                     '{5'b00000, 64'h0, 64'hFFFFFFFFFFFFFFFF, 5'd5, 1'b1, 1'b0}};
        vecs[1]  = '{32'h41F1509B, 64'h0, 64'h80000000, 64'h0,
                     '{5'b11101, 64'h80000000, 64'h1F, 5'd1, 1'b1, 1'b0}};
        vecs[2]  = '{32'h123451B7, 64'h0, 64'h55, 64'h0,
                     '{5'b00011, 64'h0, 64'h12345000, 5'd3, 1'b1, 1'b0}};
        vecs[3]  = '{32'h023100B3, 64'h0, 64'h1234, 64'h5678,
                     '{5'b00000, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1}};
        vecs[4]  = '{32'h00000013, 64'h0, 64'h0, 64'h0,
                     '{5'b00000, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0}};
        vecs[5]  = '{32'h800003B7, 64'h0, 64'h0, 64'h0,
                     '{5'b00011, 64'h0, 64'hFFFFFFFF80000000, 5'd7, 1'b1, 1'b0}};
        vecs[6]  = '{32'h00001517, 64'h80000000, 64'h0, 64'h0,
                     '{5'b00000, 64'h80000000, 64'h1000, 5'd10, 1'b1, 1'b0}};
        vecs[7]  = '{32'h40628233, 64'h0, 64'd10, 64'd3,
                     '{5'b01000, 64'd10, 64'd3, 5'd4, 1'b1, 1'b0}};
        vecs[8]  = '{32'h03F09093, 64'h0, 64'h1, 64'h0,
                     '{5'b00001, 64'h1, 64'h3F, 5'd1, 1'b1, 1'b0}};
        vecs[9]  = '{32'h0200909B, 64'h0, 64'h9, 64'h0,
                     '{5'b00000, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1}};
        vecs[10] = '{32'h8001B113, 64'h0, 64'hABCD, 64'h0,
                     '{5'b00010, 64'hABCD, 64'hFFFFFFFFFFFFF800, 5'd2, 1'b1, 1'b0}};
        vecs[11] = '{32'h00003083, 64'h0, 64'h7, 64'h8,
                     '{5'b00000, 64'h0, 64'h0, 5'd1, 1'b0, 1'b1}};
        vecs[12] = '{32'h0020D1BB, 64'h0, 64'hF0, 64'h0F,
                     '{5'b10101, 64'hF0, 64'h0F, 5'd3, 1'b1, 1'b0}};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'h0, 64'h0, 64'h0, 64'h0);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_beat", dut_beat(), '0);
        #4;
        rst_n = 1'b1;

        // Directed decode table at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            drive(vecs[i].inst, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            tick("vec");
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_beat", i), dut_beat(), vecs[i].exp);
        end
        in_valid = 1'b0;
        tick("vec_drain");

        // Backpressure: three offered, two taken, order kept on release.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h00100093, 64'h0, 64'h0, 64'h0); tick("bp1");
        drive(32'h00200113, 64'h0, 64'h0, 64'h0); tick("bp2");
        chk("bp_full_in_ready", in_ready, 1'b0);
        drive(32'h00300193, 64'h0, 64'h0, 64'h0); tick("bp3");
        chk("bp_hold_rd", out_rd, 5'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick("bp_rel1");
        chk("bp_second_rd", out_rd, 5'd2);
        chk("bp_ready_back", in_ready, 1'b1);
        tick("bp_rel2");

        // Flush with both entries full and a beat offered.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'h00A00213, 64'h0, 64'h0, 64'h0); tick("fl1");
        drive(32'h00B00293, 64'h0, 64'h0, 64'h0); tick("fl2");
        flush = 1'b1;
        drive(32'h00C00313, 64'h0, 64'h0, 64'h0); tick("fl3");
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick("fl_after1");
        tick("fl_after2");

        // Asynchronous reset mid-stream.
        out_ready = 1'b0; in_valid = 1'b1;
        drive(32'hFFF00293, 64'h0, 64'h0, 64'h0); tick("ar1");
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_beat", dut_beat(), '0);
        q.delete();
        #2 rst_n = 1'b1;
        tick("ar_idle");
        out_ready = 1'b1; in_valid = 1'b1;
        drive(32'h123451B7, 64'h0, 64'h0, 64'h0); tick("ar_first");
        chk("arst_first_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick("ar_drain");

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            drive(rand_inst(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_alu_issue.md
Name: ysyx_220066_alu_issue

Overview:
Issue stage for the EX-stage ALU. It decodes RV64I integer-ALU instructions into the team's 5-bit aluctr encoding and selects operand A and operand B. It registers the result into a 2-entry skid-buffered pipeline register with valid/ready handshakes on both sides. It sits between the register-file read stage and the ALU, and drives the ALU's data_input, datab_input and aluctr directly.

Parameters:
XLEN, 64, datapath width; only 64 is supported.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_inst  in  32  instruction word
in_pc  in  64  instruction PC
in_rs1  in  64  rs1 register value
in_rs2  in  64  rs2 register value
out_valid  out  1  issued beat valid
out_ready  in  1  ALU stage accepts beat
out_aluctr  out  5  {W, SUB/ARITH/SIGNED, op[2:0]}
out_data_a  out  64  ALU operand A
out_data_b  out  64  ALU operand B
out_rd  out  5  destination register
out_wen  out  1  write-back enable
out_illegal  out  1  instruction not handled by this unit

Behaviour:
- aluctr op[2:0] encoding:
  - 0 add/sub
  - 1 sll
  - 2 slt/sltu
  - 3 pass B
  - 4 xor
  - 5 srl/sra
  - 6 or
  - 7 and
  - Bit 3 selects sub/arith/signed. Bit 4 selects a 32-bit W op.
- OP-IMM (0x13): B = sext(imm[11:0]), A = rs1.
  - addi 00000, slti 01010, sltiu 00010, xori 00100, ori 00110, andi 00111.
  - slli 00001, requires funct6=0. srli 00101, requires funct6=0. srai 01101, requires funct6=010000.
  - For all shifts, B = zext(inst[25:20]).
- OP (0x33): funct7 must be 0000000, or 0100000 for sub/sra only; any other value is illegal (this includes M-extension funct7=0000001).
  - add 00000, sub 01000, sll 00001, slt 01010, sltu 00010, xor 00100, srl 00101, sra 01101, or 00110, and 00111.
- OP-IMM-32 (0x1B): addiw 10000.
  - slliw 10001, srliw 10101, sraiw 11101.
  - For these shifts, inst[25] must be 0, and B = zext(inst[24:20]).
- OP-32 (0x3B): addw 10000, subw 11000, sllw 10001, srlw 10101, sraw 11101. Other funct3/funct7 combinations are illegal.
- LUI (0x37): aluctr 00011, A = 0, B = sext({inst[31:12], 12'b0}).
- AUIPC (0x17): aluctr 00000, A = pc, B = sext({inst[31:12], 12'b0}).
- Any other opcode, or an illegal funct field:
  - out_illegal = 1, out_wen = 0.
  - aluctr = 0, A = B = 0.
  - out_rd = inst[11:7].
- out_wen = legal & (rd != 0).
- Pipeline: a beat is accepted when in_valid & in_ready.
  - Latency is 1 cycle: the decoded beat appears in the output register on the next edge.
  - in_ready = !skid_valid. It is registered-derived, with no combinational path from out_ready.
  - If the output register is full and out_ready=0 when a beat is accepted, the beat goes to the skid register.
  - When the output drains, the skid contents move into the output register on the same edge.
  - Order is strictly preserved.
- Boundary cases:
  - Both entries full: in_ready = 0, and in_valid is ignored.
  - out_ready=1 and a new accept in the same cycle: the output register is replaced by the skid entry if present, otherwise by the new beat. No bubble at full throughput.
  - flush=1: both entries are invalidated on the next edge, and any beat accepted that cycle is dropped. in_ready = 1 the following cycle. flush has priority over all other events.
  - Outputs are held stable while out_valid & !out_ready.
- Reset (asynchronous, active-low):
  - out_valid = 0, skid_valid = 0, in_ready = 1.
  - out_aluctr, out_data_a, out_data_b, out_rd, out_wen and out_illegal are all 0.
  - In-flight beats are lost.

Decomposition:
- Shared package ysyx_220066_pkg holds:
  - opcode constants (OP_IMM, OP, OP_IMM32, OP32, LUI, AUIPC)
  - ALU op constants ALU_ADD..ALU_AND
  - the aluctr bit positions (W=4, SUB=3)
  - the issue-beat struct {aluctr, a, b, rd, wen, illegal}
- Combinational decoder sub-module: ysyx_220066_alu_issue_dec (inst, pc, rs1, rs2 → beat).
- The top level contains only the 2-entry skid buffer control.

Test Plan:
- addi x5,x0,-1 (0xFFF00293), rs1=0, out_ready=1 → next cycle: out_valid=1, aluctr=00000, a=0, b=0xFFFFFFFFFFFFFFFF, rd=5, wen=1, illegal=0.
- sraiw x1,x2,31 (0x41F1509B), rs1=0x80000000 → aluctr=11101, b=0x1F, wen=1. lui x3,0x12345 (0x123451B7) → aluctr=00011, a=0, b=0x12345000.
- mul x1,x2,x3 (0x023100B3) → illegal=1, wen=0, aluctr=0, a=b=0, rd=1. addi x0,x0,0 → wen=0, illegal=0.
- Backpressure: out_ready=0, three back-to-back beats offered → two accepted, in_ready=0 from cycle 2. Then out_ready=1 → beats emerge in order on consecutive cycles and in_ready returns to 1.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed beats never appear.
- Assert rst_n low mid-stream with out_valid=1 (asynchronous, off the clock edge) → out_valid=0 and all outputs 0 immediately. After release, the first accepted beat issues with 1-cycle latency.
